axi4_lite_read_arbiter: RTL and testbench
=========================================

// Module: axi4_lite_read_arbiter
// PURPOSE
//   Shares one AXI4-Lite read slave port among NUM_MASTERS read masters.
//   Round-robin arbitration, one outstanding transaction at a time.
//   AR channel of the winner is passed to the slave; its R response is routed
//   back to that master only. Sits between bus masters and the read slave.
// PARAMETERS
//   NUM_MASTERS  2   number of requesters; legal range 2..8
//   ADDR_WIDTH   32  address width
//   DATA_WIDTH   32  data width
//   GW               localparam = $clog2(NUM_MASTERS), grant index width
// PORTS
//   clk          in   1               clock, all logic on rising edge
//   resetn       in   1               asynchronous reset, active low
//   M_AR_ADDR    in   NUM_MASTERS*AW  master i address at [i*AW +: AW]
//   M_AR_VALID   in   NUM_MASTERS     per-master address valid
//   M_AR_READY   out  NUM_MASTERS     per-master address ready
//   M_R_DATA     out  NUM_MASTERS*DW  master i read data at [i*DW +: DW]
//   M_R_RESP     out  NUM_MASTERS*2   master i response at [i*2 +: 2]
//   M_R_VALID    out  NUM_MASTERS     per-master read valid
//   M_R_READY    in   NUM_MASTERS     per-master read ready
//   S_AR_ADDR    out  AW              address to slave
//   S_AR_VALID   out  1               address valid to slave
//   S_AR_READY   in   1               slave address ready
//   S_R_DATA     in   DW              slave read data
//   S_R_RESP     in   2               slave read response
//   S_R_VALID    in   1               slave read valid
//   S_R_READY    out  1               read ready to slave
//   GRANT_ID     out  GW              index of current/last granted master
//   BUSY         out  1               1 when state != IDLE
// BEHAVIOUR
//   Reset (resetn=0, async): state=IDLE, grant=0, last_grant=NUM_MASTERS-1.
//   All M_* and S_* outputs are 0 in reset. Reset mid-transaction abandons it.
//   States: IDLE -> ADDR -> DATA -> IDLE (registered 2-bit state).
//   IDLE: if any M_AR_VALID, winner = first valid index scanning from
//     last_grant+1 upward, wrapping NUM_MASTERS-1 -> 0; grant<=winner; ->ADDR.
//     No valid: stay. Arbitration costs exactly 1 cycle; no READY in IDLE.
//   ADDR: S_AR_VALID=1 (from state, never from master); S_AR_ADDR=grant's addr;
//     M_AR_READY[grant]=S_AR_READY, other M_AR_READY=0.
//     S_AR_VALID&&S_AR_READY -> DATA.
//   DATA: S_R_READY=M_R_READY[grant]; M_R_VALID[grant]=S_R_VALID;
//     M_R_DATA/M_R_RESP of grant = S_R_DATA/S_R_RESP; non-granted lanes 0.
//     S_R_VALID&&S_R_READY -> IDLE, last_grant<=grant.
//   READY/VALID pass-through is combinational: no added latency beyond state.
//   Non-granted masters see READY=0 and VALID=0 in every state.
//   Requests arriving during a transaction wait; no request is ever dropped.
//   Back-to-back: earliest new S_AR_VALID is 1 cycle after R handshake.
//   S_R_VALID in IDLE/ADDR is ignored (S_R_READY=0).
//   GRANT_ID=grant register; BUSY=(state!=IDLE).
// CONFIGURATION
//   AXIL_RD_ARB_FIXED_PRIO_EN
//     defined: fixed priority, lowest index wins; last_grant unused.
//     undefined (default): round-robin as described above.
// TESTING
//   1 reset, M0..M1 idle -> all outputs 0, BUSY=0, no S_AR_VALID ever.
//   2 M1 reads 0x10, slave returns 0xDEADBEEF/OKAY -> M_R_DATA[1]=0xDEADBEEF,
//     M_R_VALID[0] stays 0, AR handshake 2 cycles after M_AR_VALID rise.
//   3 M0,M1 both hold AR_VALID continuously, 4 reads -> grants 0,1,0,1
//     (with FIXED_PRIO_EN: 0,0,0,0 while M0 keeps requesting).
//   4 slave S_AR_READY low 5 cycles, M_R_READY low 3 cycles -> S_AR_VALID held,
//     addr stable, S_R_READY follows M_R_READY, single R handshake.
//   5 resetn pulsed low in DATA -> outputs 0 immediately, state IDLE,
//     next request from M0 wins first.
//   6 slave returns SLVERR (2'b10) to M1 -> M_R_RESP[1]=2'b10, others 0.

Source files
------------

// File: rtl/axi4_lite_read_arbiter.sv
// axi4_lite_read_arbiter
//   Shares one AXI4-Lite read slave among NUM_MASTERS read masters.
//   One transaction in flight at a time: IDLE (arbitrate) -> ADDR -> DATA.
//   Round-robin arbitration by default. Defining AXIL_RD_ARB_FIXED_PRIO_EN
//   switches to fixed priority, where the lowest index always wins.
//   Handshake signals are forwarded combinationally once a master holds the
//   grant. Masters without the grant always see READY/VALID low and zero data.
module axi4_lite_read_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_AR_ADDR,
    input  logic [NUM_MASTERS-1:0]            M_AR_VALID,
    output logic [NUM_MASTERS-1:0]            M_AR_READY,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] M_R_DATA,
    output logic [NUM_MASTERS*2-1:0]          M_R_RESP,
    output logic [NUM_MASTERS-1:0]            M_R_VALID,
    input  logic [NUM_MASTERS-1:0]            M_R_READY,
    output logic [ADDR_WIDTH-1:0]             S_AR_ADDR,
    output logic                              S_AR_VALID,
    input  logic                              S_AR_READY,
    input  logic [DATA_WIDTH-1:0]             S_R_DATA,
    input  logic [1:0]                        S_R_RESP,
    input  logic                              S_R_VALID,
    output logic                              S_R_READY,
    output logic [$clog2(NUM_MASTERS)-1:0]    GRANT_ID,
    output logic                              BUSY
);

    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [GW-1:0] grant_reg;
    logic [GW-1:0] grant_next;
    logic [GW-1:0] winner;
    logic          winner_found;

`ifdef AXIL_RD_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest requesting index is kept.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (M_AR_VALID[i]) begin
                winner       = GW'(i);
                winner_found = 1'b1;
            end
        end
    end
`else
    logic [GW-1:0] last_grant_reg;
    logic [GW-1:0] last_grant_next;

    // Round-robin: first requester found scanning upward from last_grant+1 with wrap.
    always_comb begin
        int idx;
        winner       = '0;
        winner_found = 1'b0;
        idx          = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(last_grant_reg) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!winner_found && M_AR_VALID[idx]) begin
                winner       = GW'(idx);
                winner_found = 1'b1;
            end
        end
    end
`endif

    // State, grant and arbitration history registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
`ifndef AXIL_RD_ARB_FIXED_PRIO_EN
            last_grant_reg <= GW'(NUM_MASTERS - 1);
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
`ifndef AXIL_RD_ARB_FIXED_PRIO_EN
            last_grant_reg <= last_grant_next;
`endif
        end
    end

    // Next-state logic plus the slave-facing outputs, all derived from state.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
`ifndef AXIL_RD_ARB_FIXED_PRIO_EN
        last_grant_next = last_grant_reg;
`endif
        S_AR_VALID      = 1'b0;
        S_AR_ADDR       = '0;
        S_R_READY       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (winner_found) begin
                    grant_next = winner;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                S_AR_VALID = 1'b1;
                S_AR_ADDR  = M_AR_ADDR[int'(grant_reg)*ADDR_WIDTH +: ADDR_WIDTH];
                if (S_AR_READY) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                S_R_READY = M_R_READY[grant_reg];
                if (S_R_VALID && M_R_READY[grant_reg]) begin
                    state_next      = ST_IDLE;
`ifndef AXIL_RD_ARB_FIXED_PRIO_EN
                    last_grant_next = grant_reg;
`endif
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Per-master lanes: only the granted lane sees the slave's handshake and data.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
        logic lane_sel;
        assign lane_sel = (grant_reg == GW'(gi));
        assign M_AR_READY[gi] = (state_reg == ST_ADDR) && lane_sel && S_AR_READY;
        assign M_R_VALID[gi]  = (state_reg == ST_DATA) && lane_sel && S_R_VALID;
        assign M_R_DATA[gi*DATA_WIDTH +: DATA_WIDTH] =
            ((state_reg == ST_DATA) && lane_sel) ? S_R_DATA : '0;
        assign M_R_RESP[gi*2 +: 2] =
            ((state_reg == ST_DATA) && lane_sel) ? S_R_RESP : 2'b00;
    end

    assign GRANT_ID = grant_reg;
    assign BUSY     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// tb_axi4_lite_read_arbiter
//   Reactive masters and slave around the arbiter. Expected transactions are
//   queued when a test sets up its requests and popped at each R handshake.
//   A small state model (IDLE/ADDR/DATA) gives the per-cycle expectations.
module tb_axi4_lite_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GW = 1;

    localparam int MS_IDLE = 0;
    localparam int MS_ADDR = 1;
    localparam int MS_DATA = 2;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N*AW-1:0] m_ar_addr = '0;
    logic [N-1:0]    m_ar_valid = '0;
    logic [N-1:0]    m_ar_ready;
    logic [N*DW-1:0] m_r_data;
    logic [N*2-1:0]  m_r_resp;
    logic [N-1:0]    m_r_valid;
    logic [N-1:0]    m_r_ready = '0;
    logic [AW-1:0]   s_ar_addr;
    logic            s_ar_valid;
    logic            s_ar_ready = 1'b0;
    logic [DW-1:0]   s_r_data = '0;
    logic [1:0]      s_r_resp = '0;
    logic            s_r_valid = 1'b0;
    logic            s_r_ready;
    logic [GW-1:0]   grant_id;
    logic            busy;

    axi4_lite_read_arbiter #(
        .NUM_MASTERS(N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .M_AR_ADDR (m_ar_addr),
        .M_AR_VALID(m_ar_valid),
        .M_AR_READY(m_ar_ready),
        .M_R_DATA  (m_r_data),
        .M_R_RESP  (m_r_resp),
        .M_R_VALID (m_r_valid),
        .M_R_READY (m_r_ready),
        .S_AR_ADDR (s_ar_addr),
        .S_AR_VALID(s_ar_valid),
        .S_AR_READY(s_ar_ready),
        .S_R_DATA  (s_r_data),
        .S_R_RESP  (s_r_resp),
        .S_R_VALID (s_r_valid),
        .S_R_READY (s_r_ready),
        .GRANT_ID  (grant_id),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            mid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // Master / slave / model state
    int            pending[N];
    logic [AW-1:0] next_addr[N];
    int            mstate = MS_IDLE;
    int            ar_stall_cfg = 0;
    int            r_stall_cfg = 0;
    int            r_delay_cfg = 0;
    logic [1:0]    resp_cfg = 2'b00;
    int            ar_wait = 0;
    int            rr_wait = 0;
    int            r_cnt = 0;
    logic          sr_valid = 1'b0;
    logic [DW-1:0] sr_data = '0;
    logic [AW-1:0] cap_addr = '0;
    logic          spurious_rvalid = 1'b0;
    int            done = 0;
    int            dut_r_hs = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave memory contents as seen by the bench slave.
    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    task automatic push_exp(input int mid, input logic [AW-1:0] a, input logic [1:0] resp);
        exp_t e;
        e.mid  = mid;
        e.addr = a;
        e.data = slave_data(a);
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic [N*DW-1:0] exp_rdata;
        logic [N*2-1:0]  exp_rresp;
        logic [N-1:0]    onehot;
        logic [AW-1:0]   eaddr;
        logic            ar_hs;
        logic            r_hs;
        int              mid;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            m_ar_valid[i]          = (pending[i] > 0);
            m_ar_addr[i*AW +: AW]  = next_addr[i];
        end
        s_ar_ready = (ar_wait == 0);
        s_r_valid  = sr_valid | spurious_rvalid;
        s_r_data   = sr_valid ? sr_data : '0;
        s_r_resp   = sr_valid ? resp_cfg : 2'b00;
        m_r_ready  = (rr_wait == 0) ? '1 : '0;
        #1;
        mid   = 0;
        eaddr = '0;
        if (mstate != MS_IDLE) begin
            if (exp_q.size() == 0) check_eq("sb_empty", exp_q.size(), 1);
            else begin
                mid   = exp_q[0].mid;
                eaddr = exp_q[0].addr;
                check_eq("grant_id", grant_id, mid);
            end
        end
        onehot      = '0;
        onehot[mid] = 1'b1;
        exp_rdata   = '0;
        exp_rresp   = '0;
        if (mstate == MS_DATA) begin
            exp_rdata[mid*DW +: DW] = s_r_data;
            exp_rresp[mid*2 +: 2]   = s_r_resp;
        end
        check_eq("busy", busy, mstate != MS_IDLE);
        check_eq("s_ar_valid", s_ar_valid, mstate == MS_ADDR);
        check_eq("s_ar_addr", s_ar_addr, (mstate == MS_ADDR) ? eaddr : '0);
        check_eq("m_ar_ready", m_ar_ready, (mstate == MS_ADDR && s_ar_ready) ? onehot : '0);
        check_eq("s_r_ready", s_r_ready, (mstate == MS_DATA) ? m_r_ready[mid] : 1'b0);
        check_eq("m_r_valid", m_r_valid, (mstate == MS_DATA && s_r_valid) ? onehot : '0);
        check_eq("m_r_data", m_r_data, exp_rdata);
        check_eq("m_r_resp", m_r_resp, exp_rresp);

        ar_hs = (mstate == MS_ADDR) && s_ar_ready;
        r_hs  = (mstate == MS_DATA) && sr_valid && m_r_ready[mid];
        if (s_r_ready && s_r_valid) dut_r_hs++;
        for (int i = 0; i < N; i++) begin
            if (m_ar_valid[i] && m_ar_ready[i]) begin
                pending[i]--;
                next_addr[i] = next_addr[i] + 4;
            end
        end
        if (ar_hs) begin
            cap_addr = s_ar_addr;
            ar_wait  = ar_stall_cfg;
            r_cnt    = r_delay_cfg;
            mstate   = MS_DATA;
        end else if (r_hs) begin
            check_eq("r_data", m_r_data[mid*DW +: DW], exp_q[0].data);
            check_eq("r_resp", m_r_resp[mid*2 +: 2], exp_q[0].resp);
            $display("read master=%0d addr=%08h data=%08h resp=%0d",
                     mid, exp_q[0].addr, m_r_data[mid*DW +: DW], m_r_resp[mid*2 +: 2]);
            void'(exp_q.pop_front());
            done++;
            sr_valid = 1'b0;
            rr_wait  = r_stall_cfg;
            mstate   = MS_IDLE;
        end else if (mstate == MS_ADDR) begin
            if (ar_wait > 0) ar_wait--;
        end else if (mstate == MS_DATA) begin
            if (sr_valid && rr_wait > 0) rr_wait--;
            if (!sr_valid) begin
                if (r_cnt == 0) begin
                    sr_valid = 1'b1;
                    sr_data  = slave_data(cap_addr);
                end else begin
                    r_cnt--;
                end
            end
        end else if (m_ar_valid != '0) begin
            mstate = MS_ADDR;
        end
    endtask

    task automatic run_reads(input int target);
        int start;
        int cyc;
        start = done;
        cyc   = 0;
        while ((done - start) < target && cyc < 300) begin
            step();
            cyc++;
        end
        check_eq("reads_done", done - start, target);
        check_eq("r_hs_count", dut_r_hs, done);
        check_eq("sb_drained", exp_q.size(), 0);
        step();
        step();
    endtask

    task automatic clear_cfg();
        ar_stall_cfg = 0;
        r_stall_cfg  = 0;
        r_delay_cfg  = 0;
        resp_cfg     = 2'b00;
        ar_wait      = 0;
        rr_wait      = 0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < N; i++) begin
            pending[i]   = 0;
            next_addr[i] = 32'h1000 * (i + 1);
        end

        // Test 1: reset values, then idle with a stray S_R_VALID
        #12;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_s_ar_valid", s_ar_valid, 1'b0);
        check_eq("rst_grant", grant_id, '0);
        check_eq("rst_m_ar_ready", m_ar_ready, '0);
        check_eq("rst_m_r_valid", m_r_valid, '0);
        @(negedge clk);
        resetn = 1'b1;
        spurious_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        spurious_rvalid = 1'b0;

        // Test 2: M1 reads 0x10, slave answers DEADBEEF/OKAY
        next_addr[1] = 32'h10;
        pending[1]   = 1;
        push_exp(1, 32'h10, 2'b00);
        run_reads(1);

        // Test 3: both masters request continuously, four reads
        pending[0] = 2;
        pending[1] = 2;
`ifdef AXIL_RD_ARB_FIXED_PRIO_EN
        push_exp(0, next_addr[0], 2'b00);
        push_exp(0, next_addr[0] + 4, 2'b00);
        push_exp(1, next_addr[1], 2'b00);
        push_exp(1, next_addr[1] + 4, 2'b00);
`else
        push_exp(0, next_addr[0], 2'b00);
        push_exp(1, next_addr[1], 2'b00);
        push_exp(0, next_addr[0] + 4, 2'b00);
        push_exp(1, next_addr[1] + 4, 2'b00);
`endif
        run_reads(4);

        // Test 4: slave AR stall 5 cycles, master R stall 3 cycles
        ar_stall_cfg = 5;
        ar_wait      = 5;
        r_stall_cfg  = 3;
        rr_wait      = 3;
        next_addr[0] = 32'h100;
        pending[0]   = 1;
        push_exp(0, 32'h100, 2'b00);
        run_reads(1);
        clear_cfg();

        // Test 6: SLVERR returned to M1
        resp_cfg   = 2'b10;
        pending[1] = 1;
        push_exp(1, next_addr[1], 2'b10);
        run_reads(1);
        clear_cfg();

        // Test 5: reset asserted while the transaction sits in DATA
        r_delay_cfg = 1000;
        pending[1]  = 1;
        push_exp(1, next_addr[1], 2'b00);
        cyc = 0;
        while (mstate != MS_DATA && cyc < 10) begin
            step();
            cyc++;
        end
        check_eq("reach_data", mstate, MS_DATA);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_grant", grant_id, '0);
        check_eq("mid_rst_s_r_ready", s_r_ready, 1'b0);
        check_eq("mid_rst_m_r_data", m_r_data, '0);
        check_eq("mid_rst_s_ar_valid", s_ar_valid, 1'b0);
        exp_q.delete();
        mstate     = MS_IDLE;
        sr_valid   = 1'b0;
        clear_cfg();
        for (int i = 0; i < N; i++) pending[i] = 0;
        m_ar_valid = '0;
        s_r_valid  = 1'b0;
        @(negedge clk);
        resetn     = 1'b1;
        pending[0] = 1;
        pending[1] = 1;
        push_exp(0, next_addr[0], 2'b00);
        push_exp(1, next_addr[1], 2'b00);
        dut_r_hs = done;
        run_reads(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
